// File: rtl/instr_rom_loader.sv
// Instruction memory for the core's fetch port, filled from a byte stream
// (little-endian word count header followed by little-endian payload words).
module instr_rom_loader #(
    parameter int ADDR_WIDTH = 14,
    parameter int SIZE_BYTES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic [31:0] rom_addr,
    output logic [31:0] rom_data,
    output logic        loaded,
    output logic        load_done,
    output logic [31:0] words_loaded
);

    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [2:0] HDR_LAST = 3'(SIZE_BYTES - 1);

    typedef enum logic [1:0] {
        ST_SIZE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_e;

    state_e                  state_q;
    logic [2:0]              cnt_q;
    logic [31:0]             n_q;
    logic [31:0]             n_d;
    logic [31:0]             word_q;
    logic [31:0]             word_d;
    logic [31:0]             words_loaded_q;
    logic                    loaded_q;
    logic                    load_done_q;
    logic [31:0]             rom_data_q;
    logic [31:0]             byte_ext_s;
    logic                    wr_en_s;
    logic [ADDR_WIDTH-1:0]   wr_idx_s;
    logic [ADDR_WIDTH-1:0]   rd_idx_s;
    logic                    unused_addr_s;
    logic [31:0]             mem [0:DEPTH-1];

    assign rd_idx_s      = rom_addr[ADDR_WIDTH+1:2];
    assign wr_idx_s      = words_loaded_q[ADDR_WIDTH-1:0];
    assign unused_addr_s = ^{rom_addr[1:0], rom_addr[31:ADDR_WIDTH+2]};

    // Header byte placement, payload word assembly and the memory write strobe.
    always_comb begin
        byte_ext_s = {24'd0, rx_data};
        n_d        = n_q | (byte_ext_s << {cnt_q[1:0], 3'b000});
        word_d     = {rx_data, word_q[31:8]};
        if ((state_q == ST_LOAD) && rx_valid && (cnt_q == 3'd3)) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Loader FSM: header capture, word counting and the READY handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_SIZE;
            cnt_q          <= 3'd0;
            n_q            <= 32'd0;
            word_q         <= 32'd0;
            words_loaded_q <= 32'd0;
            loaded_q       <= 1'b0;
            load_done_q    <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            case (state_q)
                ST_SIZE: begin
                    if (rx_valid) begin
                        n_q <= n_d;
                        if (cnt_q == HDR_LAST) begin
                            cnt_q <= 3'd0;
                            if (n_d == 32'd0) begin
                                state_q     <= ST_READY;
                                loaded_q    <= 1'b1;
                                load_done_q <= 1'b1;
                            end else begin
                                state_q <= ST_LOAD;
                            end
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (rx_valid) begin
                        word_q <= word_d;
                        if (cnt_q == 3'd3) begin
                            cnt_q          <= 3'd0;
                            words_loaded_q <= words_loaded_q + 32'd1;
                            if ((words_loaded_q + 32'd1) == n_q) begin
                                state_q     <= ST_READY;
                                loaded_q    <= 1'b1;
                                load_done_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                end
                ST_READY: begin
                    loaded_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_SIZE;
                end
            endcase
        end
    end

    // Loader write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[wr_idx_s] <= word_d;
        end
    end

    // Fetch read port, one cycle latency, gated until the image is complete.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_data_q <= 32'd0;
        end else if (loaded_q) begin
            rom_data_q <= mem[rd_idx_s];
        end else begin
            rom_data_q <= 32'd0;
        end
    end

    assign rom_data     = rom_data_q;
    assign loaded       = loaded_q;
    assign load_done    = load_done_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_instr_rom_loader.sv
// Directed self-checking bench for instr_rom_loader.
module tb_instr_rom_loader;

    logic        clk;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        loaded;
    logic        load_done;
    logic [31:0] words_loaded;

    int total;
    int bad;

    instr_rom_loader #(.ADDR_WIDTH(14), .SIZE_BYTES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .loaded       (loaded),
        .load_done    (load_done),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (gap) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        rom_addr = addr;
        tick();
        check_eq(tag, rom_data, exp);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rom_addr = 32'd0;
        tick();
        tick();
        rst = 1'b0;

        check_eq("rst_rom_data", rom_data, 32'd0);
        check_eq("rst_loaded", {31'd0, loaded}, 32'd0);
        check_eq("rst_load_done", {31'd0, load_done}, 32'd0);
        check_eq("rst_words", words_loaded, 32'd0);
        read_chk("preload_gate", 32'd0, 32'd0);

        // N=2 gapless load
        send_word(32'd2, 0);
        send_word(32'h0010_0513, 0);
        send_byte(8'h93, 0);
        send_byte(8'h05, 0);
        send_byte(8'h20, 0);
        check_eq("pre_last_loaded", {31'd0, loaded}, 32'd0);
        check_eq("pre_last_done", {31'd0, load_done}, 32'd0);
        check_eq("pre_last_words", words_loaded, 32'd1);
        rom_addr = 32'd0;
        send_byte(8'h00, 0);
        check_eq("n2_loaded", {31'd0, loaded}, 32'd1);
        check_eq("n2_done_pulse", {31'd0, load_done}, 32'd1);
        check_eq("n2_words", words_loaded, 32'd2);
        check_eq("final_write_read_gated", rom_data, 32'd0);
        tick();
        check_eq("n2_done_clear", {31'd0, load_done}, 32'd0);
        check_eq("after_final_read", rom_data, 32'h0010_0513);

        read_chk("rd_addr0", 32'd0, 32'h0010_0513);
        read_chk("rd_addr4", 32'd4, 32'h0020_0593);
        read_chk("rd_misalign5", 32'h0000_0005, 32'h0020_0593);
        read_chk("rd_alias_hi", 32'h0001_0004, 32'h0020_0593);
        read_chk("b2b_0", 32'd0, 32'h0010_0513);
        read_chk("b2b_4", 32'd4, 32'h0020_0593);
        read_chk("b2b_0b", 32'd0, 32'h0010_0513);

        // bytes in READY are ignored
        send_word(32'hFFFF_FFFF, 0);
        check_eq("ready_words_hold", words_loaded, 32'd2);
        check_eq("ready_done_low", {31'd0, load_done}, 32'd0);
        read_chk("ready_mem_hold", 32'd0, 32'h0010_0513);

        // empty image
        do_reset();
        check_eq("rst2_loaded", {31'd0, loaded}, 32'd0);
        read_chk("rst2_gate", 32'd0, 32'd0);
        send_word(32'd0, 0);
        check_eq("empty_loaded", {31'd0, loaded}, 32'd1);
        check_eq("empty_done", {31'd0, load_done}, 32'd1);
        check_eq("empty_words", words_loaded, 32'd0);
        tick();
        check_eq("empty_done_clear", {31'd0, load_done}, 32'd0);
        send_word(32'h1234_5678, 0);
        check_eq("empty_words_hold", words_loaded, 32'd0);

        // reset in the middle of a load
        do_reset();
        send_word(32'd2, 0);
        send_word(32'h4433_2211, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        check_eq("midload_words", words_loaded, 32'd1);
        do_reset();
        check_eq("midrst_words", words_loaded, 32'd0);
        check_eq("midrst_loaded", {31'd0, loaded}, 32'd0);
        send_word(32'd1, 0);
        send_word(32'hDEAD_BEEF, 0);
        check_eq("fresh_loaded", {31'd0, loaded}, 32'd1);
        check_eq("fresh_words", words_loaded, 32'd1);
        read_chk("fresh_rd0", 32'd0, 32'hDEAD_BEEF);
        read_chk("fresh_rd4_retained", 32'd4, 32'h0020_0593);

        // sparse strobes
        do_reset();
        send_word(32'd1, 20);
        send_word(32'h1234_5678, 20);
        check_eq("sparse_loaded", {31'd0, loaded}, 32'd1);
        check_eq("sparse_words", words_loaded, 32'd1);
        read_chk("sparse_rd0", 32'd0, 32'h1234_5678);
        send_word(32'hCAFE_F00D, 5);
        check_eq("sparse_ready_words", words_loaded, 32'd1);
        read_chk("sparse_ready_rd0", 32'd0, 32'h1234_5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_rom_loader.md
Name: instr_rom_loader

Overview:
- Instruction-memory responder on the core's fetch interface: returns `rom_data` for the `rom_addr` the fetch stage drives.
- Before execution, the program image is written into on-chip memory from a byte stream, typically UART RX.
- `loaded` is the go signal the core waits on; fetch reads are served only once it is high.

Parameters:
- `ADDR_WIDTH`, 14, log2 of memory depth in 32-bit words; depth = 2^ADDR_WIDTH.
- `SIZE_BYTES`, 4, number of little-endian header bytes that carry the word count N.

Ports:
- `clk`  input  1  system clock; all logic on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `rx_valid`  input  1  one-cycle strobe: `rx_data` holds a new byte.
- `rx_data`  input  8  loader byte.
- `rom_addr`  input  32  byte address from fetch.
- `rom_data`  output  32  instruction word at `rom_addr`, registered.
- `loaded`  output  1  high once the whole image is written; stays high until reset.
- `load_done`  output  1  single-cycle pulse on entering READY.
- `words_loaded`  output  32  count of words written so far.

Behaviour:
- Reset values (`rst`=1 at a rising edge):
  - `rom_data`=0, `loaded`=0, `load_done`=0, `words_loaded`=0.
  - state=SIZE; byte counter=0; N=0.
  - Memory contents are NOT cleared.
- States:
  - SIZE: on each `rx_valid`, shift the byte into N, little-endian (first byte = bits 7:0). After the 4th byte, latch N.
    - N=0: go to READY next cycle.
    - Otherwise: go to LOAD.
  - LOAD: assemble bytes little-endian into a 32-bit word. On the 4th byte of a word:
    - write the word to mem[`words_loaded` mod depth];
    - increment `words_loaded`;
    - reset the byte counter.
    - When `words_loaded` reaches N (the write of word N-1), go to READY.
  - READY: `loaded`=1. `load_done`=1 for exactly the first READY cycle. `rx_valid` is ignored; memory is read-only.
- Cycles without `rx_valid` hold all state. Gaps of any length between bytes are legal.
- Read port:
  - Word index = `rom_addr`[ADDR_WIDTH+1:2]. Bits 1:0 and bits above ADDR_WIDTH+1 are ignored, so out-of-range addresses alias.
  - Latency is exactly 1 cycle: `rom_data` at edge k+1 = mem[index(`rom_addr` at edge k)].
  - While `loaded`=0, `rom_data` is forced to 0.
- Write index wraps modulo depth when N exceeds depth. The later word overwrites the earlier one. Completion is still at N words.
- Read in the same cycle as the final write (entering READY): `rom_data` is 0 that cycle because `loaded` is still 0. The next read returns the new data.
- Reset mid-SIZE or mid-LOAD:
  - Partial word and partial header are discarded.
  - Return to SIZE; `words_loaded`=0.
  - Words already written remain in memory but are overwritten by the next load.
- Memory is inferred as a single block RAM: one write port (loader), one synchronous read port (fetch).

Test Plan:
- Load N=2:
  - Stimulus: bytes 02 00 00 00, 13 05 10 00, 93 05 20 00.
  - `load_done` pulses exactly once, 1 cycle after the 12th byte; `loaded`=1; `words_loaded`=2.
  - Read `rom_addr`=0 → 0x00100513 one cycle later.
  - Read `rom_addr`=4 → 0x00200593 one cycle later.
- Pre-load gating:
  - Stimulus: drive `rom_addr`=0 at any point before `loaded`.
  - `rom_data`=0.
  - After the N=2 load completes, the same address yields 0x00100513.
- Aliasing and misalignment (after the N=2 load):
  - `rom_addr`=0x5 → 0x00200593.
  - `rom_addr`=(2^(ADDR_WIDTH+2))+4 → 0x00200593.
  - Back-to-back reads of 0, 4, 0 produce one result per cycle, each 1 cycle after its address.
- Empty image:
  - Stimulus: bytes 00 00 00 00.
  - `loaded`=1 and `load_done` pulse 1 cycle after the 4th byte; `words_loaded`=0.
  - Further `rx_valid` bytes do not change `words_loaded`.
- Reset mid-load:
  - Stimulus: send header N=2, then 6 payload bytes, then assert `rst` for 1 cycle.
  - `words_loaded`=0 and `loaded`=0.
  - A fresh N=1 load of EF BE AD DE gives `rom_addr`=0 → 0xDEADBEEF.
- Sparse strobes:
  - Stimulus: N=1 with 0–20 idle cycles randomly inserted between bytes.
  - Result identical to the gapless case.
  - In READY, `rx_valid` bytes do not alter memory (`rom_addr`=0 still reads the loaded word).
